// File: rtl/snake_pkg.sv
// Shared constants and FSM encoding for the snake game's frame-buffer write path.
package snake_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO buffering accepted plot requests; DEPTH must be a power of two.
module plot_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  import snake_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/plot_fb_writer.sv
// Bounds-checks and buffers plot requests, writes them into the frame buffer,
// and runs a full-screen clear sweep once pending plots have drained.
module plot_fb_writer #(
  parameter int WIDTH      = snake_pkg::SCREEN_W,
  parameter int HEIGHT     = snake_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 4,
  parameter int COLOUR_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                plot_en,
  input  logic [7:0]          plot_x,
  input  logic [6:0]          plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_ready,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [14:0]         fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_wren,
  output logic [7:0]          drop_cnt
);
  import snake_pkg::*;

  localparam int                FIFO_W   = X_W + Y_W + COLOUR_W;
  localparam logic [X_W:0]      WIDTH_C  = (X_W + 1)'(WIDTH);
  localparam logic [Y_W:0]      HEIGHT_C = (Y_W + 1)'(HEIGHT);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(WIDTH * HEIGHT - 1);

  fb_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [COLOUR_W-1:0]   clr_colour_q, clr_colour_d;
  logic                  clear_busy_q, clear_busy_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  fb_wren_q, fb_wren_d;
  logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]   fb_data_q, fb_data_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]     fifo_wdata, fifo_rdata;
  logic [X_W-1:0]        head_x;
  logic [Y_W-1:0]        head_y;
  logic [COLOUR_W-1:0]   head_colour;
  logic                  in_range, accept;

  // Row-major address; the 160-wide screen uses y*128 + y*32 instead of a multiplier.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] xw, yw;
    xw = ADDR_W'(x);
    yw = ADDR_W'(y);
    if (WIDTH == 160) return (yw << 7) + (yw << 5) + xw;
    else              return yw * ADDR_W'(WIDTH) + xw;
  endfunction

  assign in_range   = ({1'b0, plot_x} < WIDTH_C) && ({1'b0, plot_y} < HEIGHT_C);
  assign plot_ready = (state_q == IDLE) && !fifo_full && !clear_busy_q;
  assign accept     = plot_en && plot_ready;
  assign fifo_push  = accept && in_range;
  assign fifo_pop   = (state_q != CLEAR) && !fifo_empty;
  assign fifo_wdata = {plot_x, plot_y, plot_colour};
  assign {head_x, head_y, head_colour} = fifo_rdata;

  plot_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_colour_d = clr_colour_q;
    clear_busy_d = clear_busy_q;
    drop_cnt_d   = drop_cnt_q;
    fb_wren_d    = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;

    if (accept && !in_range && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    if (fifo_pop) begin
      fb_wren_d = 1'b1;
      fb_addr_d = pix_addr(head_x, head_y);
      fb_data_d = head_colour;
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d      = DRAIN;
          clr_colour_d = clear_colour;
          clear_busy_d = 1'b1;
        end
      end
      DRAIN: begin
        // Empty here means the final queued plot was already registered out.
        if (fifo_empty) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        fb_wren_d = 1'b1;
        fb_addr_d = cnt_q;
        fb_data_d = clr_colour_q;
        if (cnt_q == FB_LAST) begin
          state_d      = IDLE;
          clear_busy_d = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_colour_q <= '0;
      clear_busy_q <= 1'b0;
      drop_cnt_q   <= '0;
      fb_wren_q    <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_colour_q <= clr_colour_d;
      clear_busy_q <= clear_busy_d;
      drop_cnt_q   <= drop_cnt_d;
      fb_wren_q    <= fb_wren_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign drop_cnt   = drop_cnt_q;
  assign fb_wren    = fb_wren_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;

endmodule
